// File: rtl/uart_rx.sv
// uart_rx -- 8N1 asynchronous serial receiver.
//
// Recovers start/8 data (LSB first)/stop frames from the Rx line, samples
// each bit at its midpoint and presents the byte with a one-cycle strobe.
// A low stop bit reports a framing error and the receiver then waits for
// the line to return high, so a held-low (break) line cannot start frames.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   Rx           in   serial line, idle high, asynchronous to clk
//   data_out     out  last correctly received byte, held until next good frame
//   data_valid   out  one-cycle pulse when data_out updates
//   frame_error  out  one-cycle pulse when the stop bit samples low
//   busy         out  high whenever the receiver is not idle
//
// States
//   IDLE      | line idle, waiting for a falling edge
//   START     | timing to mid start bit to reject glitches
//   DATA      | sampling 8 data bits at mid-bit
//   STOP      | sampling the stop bit
//   WAIT_IDLE | stop bit was low; waiting for the line to go high

module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          dv_q, dv_d;
  logic          fe_q, fe_d;

  // Two-flop synchronizer; resets to the idle (high) line level so that
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_out_q <= '0;
      dv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      dv_q       <= dv_d;
      fe_q       <= fe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    dv_d       = 1'b0;
    fe_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // Line back high at mid start bit means it was only a glitch.
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_out_d = shift_q;
            dv_d       = 1'b1;
            state_d    = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out    = data_out_q;
  assign data_valid  = dv_q;
  assign frame_error = fe_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- scoreboard bench for uart_rx (CLKS_PER_BIT = 16, 10-unit clock).
// Expected bytes are queued as frames are serialized and compared as the
// receiver strobes data_valid.

module tb_uart_rx;

  logic       clk;
  logic       reset_n;
  logic       Rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .Rx          (Rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         vcyc_q[$];
  int         cyc = 0;
  int         dv_cnt = 0;
  int         fe_cnt = 0;

  task automatic chk_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor / scoreboard pop.
  always @(negedge clk) begin
    if (data_valid || frame_error)
      chk_val("pulse_exclusive", int'(data_valid & frame_error), 0);
    if (data_valid) begin
      dv_cnt++;
      vcyc_q.push_back(cyc);
      chk_val("sb_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk_val("data_out", int'(data_out), int'(exp_q.pop_front()));
    end
    if (frame_error) fe_cnt++;
  end

  // Bit-accurate serializer; bit_t is the bit period in time units.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit expect_good, input int bit_t);
    if (expect_good) exp_q.push_back(b);
    Rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      #(bit_t);
    end
    Rx = stop_bit;
    #(bit_t);
    if (stop_bit) Rx = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cyc, lat, dv0, fe0;
    reset_n = 1'b0;
    Rx      = 1'b1;
    idle_cycles(4);
    chk_val("rst_data_out", int'(data_out), 0);
    chk_val("rst_valid", int'(data_valid), 0);
    chk_val("rst_ferr", int'(frame_error), 0);
    chk_val("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    idle_cycles(4);
    chk_val("busy_before", int'(busy), 0);

    // 1: single good frame plus latency
    vcyc_q.delete();
    start_cyc = cyc;
    fork
      send_frame(8'hA5, 1'b1, 1'b1, 160);
      begin
        idle_cycles(40);
        chk_val("busy_mid", int'(busy), 1);
      end
    join
    idle_cycles(20);
    chk_val("a5_count", vcyc_q.size(), 1);
    if (vcyc_q.size() > 0) begin
      lat = vcyc_q[0] - start_cyc;
      chk_val("latency", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
    end
    chk_val("busy_after", int'(busy), 0);
    chk_val("a5_held", int'(data_out), 8'hA5);

    // 2: back-to-back frames
    vcyc_q.delete();
    send_frame(8'h00, 1'b1, 1'b1, 160);
    send_frame(8'hFF, 1'b1, 1'b1, 160);
    send_frame(8'h3C, 1'b1, 1'b1, 160);
    idle_cycles(20);
    chk_val("b2b_count", vcyc_q.size(), 3);
    if (vcyc_q.size() == 3) begin
      chk_val("b2b_gap1", vcyc_q[1] - vcyc_q[0], 160);
      chk_val("b2b_gap2", vcyc_q[2] - vcyc_q[1], 160);
    end

    // 3: start-bit glitch
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    Rx = 1'b0;
    #40;
    Rx = 1'b1;
    idle_cycles(30);
    chk_val("glitch_busy", int'(busy), 0);
    chk_val("glitch_no_valid", dv_cnt - dv0, 0);
    chk_val("glitch_no_ferr", fe_cnt - fe0, 0);
    send_frame(8'h5A, 1'b1, 1'b1, 160);
    idle_cycles(20);
    chk_val("5a_received", dv_cnt - dv0, 1);

    // 4: framing error followed by a break
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h81, 1'b0, 1'b0, 160);
    #(40 * 160);
    chk_val("break_busy", int'(busy), 1);
    Rx = 1'b1;
    idle_cycles(20);
    chk_val("ferr_once", fe_cnt - fe0, 1);
    chk_val("ferr_no_valid", dv_cnt - dv0, 0);
    chk_val("ferr_data_held", int'(data_out), 8'h5A);
    chk_val("break_end_busy", int'(busy), 0);
    send_frame(8'h42, 1'b1, 1'b1, 160);
    idle_cycles(20);
    chk_val("42_received", dv_cnt - dv0, 1);

    // 5: reset during data bit 4 of 0xF0
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    fork
      send_frame(8'hF0, 1'b1, 1'b0, 160);
      begin
        #880;
        reset_n = 1'b0;
        #31;
        chk_val("midrst_data_out", int'(data_out), 0);
        chk_val("midrst_busy", int'(busy), 0);
        chk_val("midrst_valid", int'(data_valid), 0);
        reset_n = 1'b1;
      end
    join
    idle_cycles(30);
    chk_val("midrst_no_valid", dv_cnt - dv0, 0);
    chk_val("midrst_no_ferr", fe_cnt - fe0, 0);
    chk_val("midrst_idle", int'(busy), 0);
    send_frame(8'h0F, 1'b1, 1'b1, 160);
    idle_cycles(20);
    chk_val("0f_data_out", int'(data_out), 8'h0F);

    // 6: bit-rate tolerance
    fe0 = fe_cnt;
    dv0 = dv_cnt;
    send_frame(8'h96, 1'b1, 1'b1, 155);
    idle_cycles(20);
    send_frame(8'h96, 1'b1, 1'b1, 165);
    idle_cycles(20);
    chk_val("rate_valid", dv_cnt - dv0, 2);
    chk_val("rate_no_ferr", fe_cnt - fe0, 0);
    chk_val("rate_data_out", int'(data_out), 8'h96);

    chk_val("sb_drained", exp_q.size(), 0);
    chk_val("total_ferr", fe_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver that recovers 8N1 frames from the `Rx` line and presents each byte as a parallel word with a one-cycle valid strobe. It is the receiving end of the team's UART link. It shares the frame format and bit-period parameter with the transmitter, so the two can be looped back for board bring-up. It sits between the pad-side serial input and any byte consumer (command parser, FIFO).

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period. Must be ≥ 8 and even.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `Rx` input 1: serial line, idle high, asynchronous to `clk`.
- `data_out` output 8: last correctly received byte; held until the next good frame.
- `data_valid` output 1: one-cycle pulse when `data_out` updates.
- `frame_error` output 1: one-cycle pulse when the stop bit samples low.
- `busy` output 1: high in every state except IDLE.

## Operation
- **Synchronizer:** `Rx` passes through a 2-flop synchronizer to form `rx_s`. Both flops reset to 1.
- **Frame format:** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- **Counters:** `clk_cnt` has width clog2(`CLKS_PER_BIT`) and counts up, with no wrap beyond `CLKS_PER_BIT`-1. `bit_idx` is 3 bits.
- **States:** IDLE, START, DATA, STOP, WAIT_IDLE.
  - **IDLE:** `clk_cnt`=0. When `rx_s`==0, go to START.
  - **START:** increment `clk_cnt`. At `clk_cnt`==`CLKS_PER_BIT`/2-1 (mid start bit), sample `rx_s`:
    - 0: go to DATA with `clk_cnt`=0 and `bit_idx`=0.
    - 1: glitch; go to IDLE with no output.
  - **DATA:** at `clk_cnt`==`CLKS_PER_BIT`-1, store `rx_s` in `shift[bit_idx]` and clear `clk_cnt`.
    - If `bit_idx`==7, go to STOP.
    - Otherwise increment `bit_idx`.
  - **STOP:** at `clk_cnt`==`CLKS_PER_BIT`-1, sample `rx_s`:
    - 1: load `data_out`<=`shift`, pulse `data_valid`, go to IDLE.
    - 0: pulse `frame_error`, leave `data_out` unchanged, go to WAIT_IDLE.
  - **WAIT_IDLE:** stay until `rx_s`==1, then go to IDLE. This prevents a held-low (break) line from re-triggering frames.
- **Pulse exclusivity:** `data_valid` and `frame_error` are never high together. Each is high for exactly one cycle.
- **Back-to-back frames:** a start bit arriving immediately after a good stop bit is accepted. IDLE is re-entered in the cycle after the stop sample.
- **Reset mid-frame:** the partial byte is discarded, the FSM returns to IDLE, and no pulse is produced.

## Timing
- **Reset values:**
  - `data_out`=8'h00, `data_valid`=0, `frame_error`=0, `busy`=0.
  - FSM=IDLE, `shift`=0, counters=0.
- **Sampling:** all samples are taken mid-bit, `CLKS_PER_BIT`/2 cycles after the detected bit edge (±2-cycle synchronizer skew).
- **Latency:** the first rising `clk` edge that samples `Rx`=0 is cycle 0. `data_valid` is high in cycle 3 + `CLKS_PER_BIT`/2 + 9×`CLKS_PER_BIT`, with ±1 tolerance allowed in the bench. For `CLKS_PER_BIT`=16 this is cycle 155±1.
- **Output update:** `data_out` changes in the same cycle that `data_valid` rises.
- **`busy` timing:** `busy` rises the cycle after IDLE→START and falls the cycle IDLE is re-entered.
- **Rate tolerance:** frames must decode correctly with the transmitter bit period off by ±3%.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and a 10 ns clock. The bench drives `Rx` from a bit-accurate serializer.
1. **Reset and single good frame:** release `reset_n`, then send 0xA5 → one `data_valid` pulse, `data_out`=8'hA5, `frame_error` never high, `busy` low before and after the frame.
2. **Back-to-back frames:** send 0x00, 0xFF, 0x3C with no idle gap → three `data_valid` pulses in order, with `data_out` reading 8'h00, 8'hFF, 8'h3C, each spaced 160 cycles apart.
3. **Start-bit glitch:** pull `Rx` low for 4 cycles, then return it high → FSM back to IDLE, no `data_valid`, no `frame_error`. A following 0x5A frame is received correctly.
4. **Framing error and break:** send 0x81 with stop bit = 0, then hold `Rx` low for 40 bit periods, then release it and send 0x42:
   - `frame_error` pulses once.
   - `data_out` keeps its previous value.
   - No further pulses occur during the break.
   - 0x42 is then received correctly.
5. **Reset mid-frame:** assert `reset_n`=0 during data bit 4 of a 0xF0 frame, then release → all outputs return to reset values and nothing is emitted. The next frame, 0x0F, gives `data_out`=8'h0F.
6. **Rate tolerance:** send 0x96 at bit periods of 15.5 and 16.5 cycles → `data_out`=8'h96 and no `frame_error` in both cases.
